ci_fft_sequencer: RTL and testbench

Frame sequencer and channel arbiter for the shared `dit` FFT core. It grants one of `N_CH` acquisition channels at a time, round-robin, and reads exactly `FFT_LEN` samples from that channel's buffer. It streams those samples into the core with the `nd` strobe, then collects the `FFT_LEN` result strobes and tags each result with its channel and bin index. It sits between the per-channel sample buffers and the result consumer. It is the only block that drives the FFT core's inputs.

---
 rtl/ci_fft_pkg.sv | 42 ++++
 rtl/ci_rr_arbiter.sv | 25 ++
 rtl/ci_fft_sequencer.sv | 144 ++++++++++++++
 tb/tb_ci_fft_sequencer.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/ci_fft_pkg.sv
// Shared definitions for the FFT frame sequencer: default sizes, FSM states,
// and the round-robin pick helper used by the arbiter.
package ci_fft_pkg;

  localparam int FFT_LEN = 64;
  localparam int DW      = 12;
  localparam int MAX_CH  = 8;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_FEED = 2'd1,
    S_WAIT = 2'd2
  } state_e;

  // Ceiling log2; returns 0 for v <= 1.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

  // Lowest-numbered requester at or after last+1 (mod n). Scanning from the
  // farthest offset down lets the nearest hit overwrite earlier ones.
  function automatic int rr_pick(input logic [MAX_CH-1:0] req, input int n,
                                 input int last);
    int idx;
    int pick;
    pick = 0;
    for (int k = MAX_CH; k >= 1; k--) begin
      if (k <= n) begin
        idx = last + k;
        if (idx >= n) idx = idx - n;
        if (req[idx[2:0]]) pick = idx;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/ci_rr_arbiter.sv
// Combinational round-robin picker; the sequencer registers its result.
module ci_rr_arbiter
  import ci_fft_pkg::*;
#(
  parameter int N_CH = 4,
  parameter int CW   = clog2(N_CH)
) (
  input  logic [N_CH-1:0] req,
  input  logic [CW-1:0]   last_ch,
  output logic [CW-1:0]   grant_idx,
  output logic            any
);

  logic [MAX_CH-1:0] req_w;

  // Widen the request vector to the helper's fixed width.
  always_comb begin
    req_w            = '0;
    req_w[N_CH-1:0]  = req;
  end

  assign grant_idx = CW'(rr_pick(req_w, N_CH, int'(last_ch)));
  assign any       = |req;

endmodule

// File: rtl/ci_fft_sequencer.sv
// Grants one channel at a time, streams a full frame into the shared FFT core,
// then tags each returned bin with its channel and index.
module ci_fft_sequencer #(
  parameter int N_CH    = 4,
  parameter int FFT_LEN = ci_fft_pkg::FFT_LEN,
  parameter int DW      = ci_fft_pkg::DW,
  parameter int CW      = ci_fft_pkg::clog2(N_CH),
  parameter int IW      = ci_fft_pkg::clog2(FFT_LEN)
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [N_CH-1:0]      ch_ready,
  output logic [N_CH-1:0]      ch_rd,
  input  logic [N_CH*DW-1:0]   ch_data,
  output logic                 fft_nd,
  output logic [2*DW-1:0]      fft_in,
  input  logic                 fft_out_nd,
  input  logic [2*DW-1:0]      fft_out,
  input  logic                 fft_ovf,
  output logic                 res_valid,
  output logic [CW-1:0]        res_ch,
  output logic [IW-1:0]        res_idx,
  output logic [DW-1:0]        res_re,
  output logic                 busy,
  output logic [7:0]           ovf_cnt
);
  import ci_fft_pkg::*;

  localparam logic [IW-1:0] FEED_LAST = IW'(FFT_LEN - 1);
  localparam logic [IW:0]   RES_FULL  = (IW+1)'(FFT_LEN);

  state_e          state_q;
  logic [CW-1:0]   cur_ch_q;
  logic [CW-1:0]   last_ch_q;
  logic [IW-1:0]   feed_cnt_q;
  logic [IW:0]     res_cnt_q;
  logic            drop_q;
  logic [N_CH-1:0] ch_rd_q;
  logic            fft_nd_q;
  logic [2*DW-1:0] fft_in_q;
  logic            res_valid_q;
  logic [CW-1:0]   res_ch_q;
  logic [IW-1:0]   res_idx_q;
  logic [DW-1:0]   res_re_q;
  logic            busy_q;
  logic [7:0]      ovf_cnt_q;

  logic [CW-1:0]   arb_idx;
  logic            arb_any;
  logic [DW-1:0]   cur_sample;
  logic            collecting;
  logic            unused_imag;

  ci_rr_arbiter #(.N_CH(N_CH), .CW(CW)) u_arb (
    .req       (ch_ready),
    .last_ch   (last_ch_q),
    .grant_idx (arb_idx),
    .any       (arb_any)
  );

  assign cur_sample  = ch_data[cur_ch_q*DW +: DW];
  // Results are accepted from the first fed sample onward, until the frame is full.
  assign collecting  = (state_q != S_IDLE) && (res_cnt_q != RES_FULL);
  assign unused_imag = ^fft_out[DW-1:0];

  // Frame FSM with all outputs registered.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      cur_ch_q    <= '0;
      last_ch_q   <= CW'(N_CH - 1);
      feed_cnt_q  <= '0;
      res_cnt_q   <= '0;
      drop_q      <= 1'b0;
      ch_rd_q     <= '0;
      fft_nd_q    <= 1'b0;
      fft_in_q    <= '0;
      res_valid_q <= 1'b0;
      res_ch_q    <= '0;
      res_idx_q   <= '0;
      res_re_q    <= '0;
      busy_q      <= 1'b0;
      ovf_cnt_q   <= '0;
    end else begin
      res_valid_q <= 1'b0;
      // The buffer's read data is captured on the edge ending its ch_rd cycle.
      fft_nd_q    <= |ch_rd_q;
      if (|ch_rd_q) fft_in_q <= {cur_sample, {DW{1'b0}}};

      case (state_q)
        S_IDLE: begin
          if (arb_any) begin
            state_q    <= S_FEED;
            busy_q     <= 1'b1;
            cur_ch_q   <= arb_idx;
            ch_rd_q    <= {{(N_CH-1){1'b0}}, 1'b1} << arb_idx;
            feed_cnt_q <= '0;
            res_cnt_q  <= '0;
            drop_q     <= 1'b0;
          end
        end
        S_FEED: begin
          feed_cnt_q <= feed_cnt_q + 1'b1;
          if (feed_cnt_q == FEED_LAST) begin
            ch_rd_q <= '0;
            state_q <= S_WAIT;
          end
        end
        S_WAIT: begin
          // Leave one cycle after the last result so IDLE follows the final res_valid.
          if (res_cnt_q == RES_FULL) begin
            state_q   <= S_IDLE;
            busy_q    <= 1'b0;
            last_ch_q <= cur_ch_q;
            if ((drop_q || fft_ovf) && ovf_cnt_q != 8'hFF) ovf_cnt_q <= ovf_cnt_q + 8'd1;
          end
        end
        default: state_q <= S_IDLE;
      endcase

      if (collecting) begin
        if (fft_ovf) drop_q <= 1'b1;
        if (fft_out_nd) begin
          res_cnt_q   <= res_cnt_q + 1'b1;
          res_valid_q <= !(drop_q || fft_ovf);
          res_ch_q    <= cur_ch_q;
          res_idx_q   <= res_cnt_q[IW-1:0];
          res_re_q    <= fft_out[2*DW-1:DW];
        end
      end
    end
  end

  assign ch_rd     = ch_rd_q;
  assign fft_nd    = fft_nd_q;
  assign fft_in    = fft_in_q;
  assign res_valid = res_valid_q;
  assign res_ch    = res_ch_q;
  assign res_idx   = res_idx_q;
  assign res_re    = res_re_q;
  assign busy      = busy_q;
  assign ovf_cnt   = ovf_cnt_q;

endmodule

// File: tb/tb_ci_fft_sequencer.sv
// Bench: random channel buffers, an echo core with fixed latency, and a
// frame-level model predicting grant order, fed samples and tagged results.
module tb_ci_fft_sequencer;
  localparam int N_CH = 4, FFT_LEN = 64, DW = 12, CW = 2, IW = 6, DLY = 10;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                reset_n;
  logic [N_CH-1:0]     ch_ready;
  logic [N_CH-1:0]     ch_rd;
  logic [N_CH*DW-1:0]  ch_data;
  logic                fft_nd;
  logic [2*DW-1:0]     fft_in;
  logic                fft_out_nd;
  logic [2*DW-1:0]     fft_out;
  logic                fft_ovf;
  logic                res_valid;
  logic [CW-1:0]       res_ch;
  logic [IW-1:0]       res_idx;
  logic [DW-1:0]       res_re;
  logic                busy;
  logic [7:0]          ovf_cnt;

  ci_fft_sequencer #(.N_CH(N_CH), .FFT_LEN(FFT_LEN), .DW(DW), .CW(CW), .IW(IW)) dut (
    .clk(clk), .reset_n(reset_n), .ch_ready(ch_ready), .ch_rd(ch_rd), .ch_data(ch_data),
    .fft_nd(fft_nd), .fft_in(fft_in), .fft_out_nd(fft_out_nd), .fft_out(fft_out),
    .fft_ovf(fft_ovf), .res_valid(res_valid), .res_ch(res_ch), .res_idx(res_idx),
    .res_re(res_re), .busy(busy), .ovf_cnt(ovf_cnt)
  );

  // Channel buffers: first-word-fall-through, pointer advances on each read.
  logic [DW-1:0] mem [N_CH][1024];
  logic [9:0]    ptr [N_CH];

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) for (int c = 0; c < N_CH; c++) ptr[c] <= '0;
    else for (int c = 0; c < N_CH; c++) if (ch_rd[c]) ptr[c] <= ptr[c] + 10'd1;
  end

  always_comb begin
    ch_data = '0;
    for (int c = 0; c < N_CH; c++) ch_data[c*DW +: DW] = mem[c][ptr[c]];
  end

  // Echo core: every input reappears as a result DLY cycles later.
  logic [DLY-1:0]  nd_pipe = '0;
  logic [2*DW-1:0] dat_pipe [DLY];
  int              out_cnt = 0;
  logic            stray, ovf_arm;
  logic [2*DW-1:0] stray_dat;
  int              ovf_at;

  always @(posedge clk) begin
    nd_pipe     <= {nd_pipe[DLY-2:0], fft_nd};
    dat_pipe[0] <= fft_in;
    for (int i = 1; i < DLY; i++) dat_pipe[i] <= dat_pipe[i-1];
    if (!busy) out_cnt <= 0;
    else if (nd_pipe[DLY-1]) out_cnt <= out_cnt + 1;
  end

  assign fft_out_nd = nd_pipe[DLY-1] | stray;
  assign fft_out    = stray ? stray_dat : dat_pipe[DLY-1];
  assign fft_ovf    = ovf_arm && nd_pipe[DLY-1] && (out_cnt == ovf_at);

  // Monitor, sampled on the falling edge.
  int               rd_cycles = 0, onehot_bad = 0, overlap_bad = 0;
  int               grant_q [$];
  logic [2*DW-1:0]  nd_q [$];
  logic [CW+IW+DW-1:0] res_q [$];
  logic [N_CH-1:0]  prev_rd = '0;
  logic             prev_busy = 1'b0;

  always @(negedge clk) begin
    if (ch_rd != '0) begin
      rd_cycles++;
      if (!$onehot(ch_rd)) onehot_bad++;
      if (prev_rd == '0) begin
        for (int c = N_CH - 1; c >= 0; c--) if (ch_rd[c]) begin grant_q.push_back(c); break; end
        if (prev_busy) overlap_bad++;
      end
    end
    if (fft_nd) nd_q.push_back(fft_in);
    if (res_valid) res_q.push_back({res_ch, res_idx, res_re});
    prev_rd   = ch_rd;
    prev_busy = busy;
  end

  int n_checks = 0, n_fail = 0;
  int model_last, model_ovf;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_mon();
    rd_cycles = 0; onehot_bad = 0; overlap_bad = 0;
    grant_q.delete(); nd_q.delete(); res_q.delete();
  endtask

  task automatic wait_busy(input logic val, input int budget, input string tag);
    int n = 0;
    while (busy !== val && n < budget) begin @(posedge clk); #2; n++; end
    check(tag, busy, val);
  endtask

  // Next grant: first ready channel scanning forward from the last served one.
  function automatic int model_pick(input logic [N_CH-1:0] r);
    for (int k = 1; k <= N_CH; k++) if (r[(model_last + k) % N_CH]) return (model_last + k) % N_CH;
    return 0;
  endfunction

  // One whole frame; drop_at >= 0 raises overflow on that result (0-based).
  task automatic do_frame(input logic [N_CH-1:0] ready, input bit hold, input int drop_at);
    int ch, n_res;
    logic [9:0] p0;
    logic [DW-1:0] s;
    ch = model_pick(ready);
    p0 = ptr[ch];
    clear_mon();
    ovf_at  = drop_at;
    ovf_arm = (drop_at >= 0);
    ch_ready = ready;
    wait_busy(1'b1, 20, "busy_rise");
    if (!hold) ch_ready = '0;
    wait_busy(1'b0, 400, "busy_fall");
    ovf_arm = 1'b0;
    check("grant_count", grant_q.size(), 1);
    if (grant_q.size() > 0) check("grant_ch", grant_q[0], ch);
    check("rd_cycles", rd_cycles, FFT_LEN);
    check("nd_count", nd_q.size(), FFT_LEN);
    for (int i = 0; i < nd_q.size() && i < FFT_LEN; i++) begin
      s = mem[ch][p0 + 10'(i)];
      check("nd_data", nd_q[i], {s, {DW{1'b0}}});
    end
    n_res = (drop_at >= 0) ? drop_at : FFT_LEN;
    check("res_count", res_q.size(), n_res);
    for (int i = 0; i < res_q.size() && i < n_res; i++) begin
      s = mem[ch][p0 + 10'(i)];
      check("res_tag", res_q[i], {CW'(ch), IW'(i), s});
    end
    check("onehot", onehot_bad, 0);
    check("no_overlap", overlap_bad, 0);
    model_last = ch;
    if (drop_at >= 0 && model_ovf < 255) model_ovf++;
    check("ovf_cnt", ovf_cnt, model_ovf);
  endtask

  initial begin
    int n;
    reset_n = 1'b0; ch_ready = '0; stray = 1'b0; stray_dat = '0; ovf_arm = 1'b0; ovf_at = 0;
    for (int c = 0; c < N_CH; c++)
      for (int i = 0; i < 1024; i++) mem[c][i] = DW'($urandom);
    for (int i = 0; i < FFT_LEN; i++) mem[0][i] = DW'(i);

    repeat (3) @(posedge clk); #2;
    check("rst_ch_rd", ch_rd, 0);
    check("rst_fft_nd", fft_nd, 0);
    check("rst_res_valid", res_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_ovf_cnt", ovf_cnt, 0);
    reset_n = 1'b1;
    model_last = N_CH - 1; model_ovf = 0;
    repeat (2) @(posedge clk); #2;

    // Single channel with ramp data.
    do_frame(4'b0001, 1'b0, -1);
    // Round robin with all channels ready.
    for (int r = 0; r < 5; r++) do_frame(4'b1111, r < 4, -1);
    // Skip non-ready channels.
    do_frame(4'b1010, 1'b1, -1);
    do_frame(4'b1010, 1'b0, -1);
    // Overflow on the fifth result, then a normal frame.
    do_frame(4'b0100, 1'b0, 4);
    for (int r = 0; r < 4; r++) do_frame(4'($urandom_range(1, 15)), 1'b0, -1);

    // Stray result while idle.
    clear_mon();
    stray_dat = {DW'($urandom), {DW{1'b0}}};
    stray = 1'b1;
    @(posedge clk); #2;
    stray = 1'b0;
    repeat (3) @(posedge clk); #2;
    check("stray_res", res_q.size(), 0);
    check("stray_busy", busy, 0);
    check("stray_rd", rd_cycles, 0);

    // Reset in the middle of feeding.
    clear_mon();
    ch_ready = 4'b0110;
    wait_busy(1'b1, 20, "mid_busy_rise");
    n = 0;
    while (rd_cycles < 20 && n < 100) begin @(posedge clk); #2; n++; end
    check("mid_feed_cnt", rd_cycles, 20);
    reset_n = 1'b0;
    #1;
    check("mid_ch_rd", ch_rd, 0);
    check("mid_fft_nd", fft_nd, 0);
    check("mid_busy", busy, 0);
    check("mid_res_valid", res_valid, 0);
    check("mid_ovf_cnt", ovf_cnt, 0);
    ch_ready = '0;
    repeat (15) @(posedge clk); #2;
    reset_n = 1'b1;
    model_last = N_CH - 1; model_ovf = 0;
    @(posedge clk); #2;
    do_frame(4'b1111, 1'b0, -1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
